// File: rtl/rv32i_wb_arb_pkg.sv
// rv32i_wb_arb_pkg: shared widths and types for the two-master Wishbone arbiter
package rv32i_wb_arb_pkg;
    localparam int WB_ADR_W = 32;
    localparam int WB_DAT_W = 32;
    localparam int WB_SEL_W = 4;

    typedef enum logic [1:0] {IDLE, OWN0, OWN1} arb_state_t;
    typedef logic master_idx_t;

    function automatic arb_state_t own_state(input master_idx_t m);
        return m ? OWN1 : OWN0;
    endfunction
endpackage

// File: rtl/rv32i_wb_arb_pick.sv
// rv32i_wb_arb_pick: two-way grant pick, fixed data priority or last-owner-loses round robin
module rv32i_wb_arb_pick
    import rv32i_wb_arb_pkg::*;
#(
    parameter int DATA_PRIO = 1
) (
    input  logic        req0,
    input  logic        req1,
    input  master_idx_t last,
    output master_idx_t grant
);
    always_comb grant = (req0 & req1) ? ((DATA_PRIO != 0) ? 1'b1 : ~last) : req1;
endmodule

// File: rtl/rv32i_mem_wb_arbiter.sv
// rv32i_mem_wb_arbiter: shares one pipelined Wishbone slave between the fetch (M0) and data (M1) adapters,
// holding ownership per transaction group and releasing on idle boundaries
module rv32i_mem_wb_arbiter
    import rv32i_wb_arb_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 4,
    parameter int MAX_BURST       = 8,
    parameter int DATA_PRIO       = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                m0_cyc_i,
    input  logic                m0_stb_i,
    input  logic                m0_we_i,
    input  logic [WB_ADR_W-1:0] m0_adr_i,
    input  logic [WB_DAT_W-1:0] m0_dat_i,
    input  logic [WB_SEL_W-1:0] m0_sel_i,
    output logic                m0_stall_o,
    output logic                m0_ack_o,
    output logic                m0_err_o,
    output logic [WB_DAT_W-1:0] m0_dat_o,
    input  logic                m1_cyc_i,
    input  logic                m1_stb_i,
    input  logic                m1_we_i,
    input  logic [WB_ADR_W-1:0] m1_adr_i,
    input  logic [WB_DAT_W-1:0] m1_dat_i,
    input  logic [WB_SEL_W-1:0] m1_sel_i,
    output logic                m1_stall_o,
    output logic                m1_ack_o,
    output logic                m1_err_o,
    output logic [WB_DAT_W-1:0] m1_dat_o,
    output logic                s_cyc_o,
    output logic                s_stb_o,
    output logic                s_we_o,
    output logic [WB_ADR_W-1:0] s_adr_o,
    output logic [WB_DAT_W-1:0] s_dat_o,
    output logic [WB_SEL_W-1:0] s_sel_o,
    input  logic                s_stall_i,
    input  logic                s_ack_i,
    input  logic                s_err_i,
    input  logic [WB_DAT_W-1:0] s_dat_i
);
    localparam int OW = $clog2(MAX_OUTSTANDING + 1);
    localparam int BW = $clog2(MAX_BURST + 1);
    localparam logic [OW-1:0] OMAX = OW'(MAX_OUTSTANDING);
    localparam logic [BW-1:0] BMAX = BW'(MAX_BURST);

    arb_state_t    state, state_nxt;
    logic [OW-1:0] outstanding, out_nxt;
    logic [BW-1:0] burst, burst_nxt;
    master_idx_t   last, last_nxt, pick_idx, own;
    logic          req0, req1, owning, own_cyc, own_stb, own_req, other_req;
    logic          block, accept, retire, abort, rel;

    assign req0 = m0_cyc_i & m0_stb_i;
    assign req1 = m1_cyc_i & m1_stb_i;

    rv32i_wb_arb_pick #(.DATA_PRIO(DATA_PRIO)) u_pick (
        .req0  (req0),
        .req1  (req1),
        .last  (last),
        .grant (pick_idx)
    );

    always_comb begin
        owning    = state != IDLE;
        own       = state == OWN1;
        own_cyc   = own ? m1_cyc_i : m0_cyc_i;
        own_stb   = own ? m1_stb_i : m0_stb_i;
        own_req   = own_cyc & own_stb;
        other_req = own ? req0 : req1;
        block     = (outstanding == OMAX) | ((burst == BMAX) & other_req);
        s_cyc_o   = owning & own_cyc;
        s_stb_o   = s_cyc_o & own_stb & ~block;
        s_we_o    = owning & (own ? m1_we_i : m0_we_i);
        s_adr_o   = owning ? (own ? m1_adr_i : m0_adr_i) : '0;
        s_dat_o   = owning ? (own ? m1_dat_i : m0_dat_i) : '0;
        s_sel_o   = owning ? (own ? m1_sel_i : m0_sel_i) : '0;
        accept    = s_stb_o & ~s_stall_i;
        retire    = owning & (s_ack_i | s_err_i) & (outstanding != '0);
        // Dropping cyc abandons whatever is in flight; its late acks land in IDLE and are dropped
        abort     = owning & ~own_cyc & (outstanding != '0);
        out_nxt   = abort ? '0 : outstanding + OW'(accept) - OW'(retire);
        rel       = owning & ~abort & (out_nxt == '0) & (~own_req | block);
        state_nxt = state;
        last_nxt  = last;
        if (!owning) begin
            state_nxt = (req0 | req1) ? own_state(pick_idx) : IDLE;
        end else if (abort | rel) begin
            state_nxt = (rel & other_req) ? own_state(~own) : IDLE;
            last_nxt  = own;
        end
        burst_nxt  = (state_nxt != state) ? '0 : burst + BW'(accept & (burst != BMAX));
        m0_stall_o = ~(owning & ~own) | s_stall_i | block;
        m1_stall_o = ~own | s_stall_i | block;
        m0_ack_o   = s_ack_i & owning & ~own;
        m0_err_o   = s_err_i & owning & ~own;
        m1_ack_o   = s_ack_i & own;
        m1_err_o   = s_err_i & own;
        m0_dat_o   = s_dat_i;
        m1_dat_o   = s_dat_i;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            outstanding <= '0;
            burst       <= '0;
            last        <= 1'b0;
        end else begin
            state       <= state_nxt;
            outstanding <= out_nxt;
            burst       <= burst_nxt;
            last        <= last_nxt;
        end
    end
endmodule

// File: tb/tb_rv32i_mem_wb_arbiter.sv
// tb_rv32i_mem_wb_arbiter: scenario tasks plus randomized traffic against a transaction-level master/slave model
module tb_rv32i_mem_wb_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        m0_cyc_i = 0, m0_stb_i = 0, m0_we_i = 0, m1_cyc_i = 0, m1_stb_i = 0, m1_we_i = 0;
    logic [31:0] m0_adr_i = '0, m0_dat_i = '0, m1_adr_i = '0, m1_dat_i = '0;
    logic [3:0]  m0_sel_i = '0, m1_sel_i = '0;
    logic        m0_stall_o, m0_ack_o, m0_err_o, m1_stall_o, m1_ack_o, m1_err_o;
    logic [31:0] m0_dat_o, m1_dat_o;
    logic        s_cyc_o, s_stb_o, s_we_o;
    logic [31:0] s_adr_o, s_dat_o;
    logic [3:0]  s_sel_o;
    logic        s_stall_i = 0, s_ack_i = 0, s_err_i = 0;
    logic [31:0] s_dat_i = '0;

    int tests = 0, fails = 0, cyc_n = 0;
    logic [31:0] q0[$], q1[$];
    logic [32:0] e0[$], e1[$], sq_rsp[$];
    int sq_due[$], acc_log[$], acc_cl[$];
    bit en0 = 1, en1 = 1, keep0 = 0, kill1 = 0, rnd = 0, stb0_q = 0;
    int dly = 2, pend0 = 0, pend1 = 0, maxp = 0, stray = 0, derr = 0, both = 0;
    int acc0 = 0, acc1 = 0, rsp0 = 0, rsp1 = 0, req0_cyc = 0, rsp0_cyc = 0, last_rsp1_cyc = 0;
    logic [31:0] rsp0_dat = '0;

    always #5 clk = ~clk;

    rv32i_mem_wb_arbiter #(.MAX_OUTSTANDING(4), .MAX_BURST(8), .DATA_PRIO(1)) dut (
        .clk(clk), .rst(rst),
        .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i), .m0_adr_i(m0_adr_i),
        .m0_dat_i(m0_dat_i), .m0_sel_i(m0_sel_i), .m0_stall_o(m0_stall_o), .m0_ack_o(m0_ack_o),
        .m0_err_o(m0_err_o), .m0_dat_o(m0_dat_o),
        .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i), .m1_adr_i(m1_adr_i),
        .m1_dat_i(m1_dat_i), .m1_sel_i(m1_sel_i), .m1_stall_o(m1_stall_o), .m1_ack_o(m1_ack_o),
        .m1_err_o(m1_err_o), .m1_dat_o(m1_dat_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_adr_o(s_adr_o),
        .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_stall_i(s_stall_i), .s_ack_i(s_ack_i),
        .s_err_i(s_err_i), .s_dat_i(s_dat_i)
    );

    function automatic logic [31:0] mem(input logic [31:0] a);
        return (a == 32'h8000_0004) ? 32'h0000_0013 : {a[15:0] ^ 16'h5a5a, ~a[31:16]};
    endfunction

    // Drive phase: 1 ns after each rising edge, masters present their queue heads and the slave replays responses
    always @(posedge clk) begin
        #1;
        cyc_n++;
        s_stall_i = rnd && ($urandom_range(3) == 0);
        if (sq_due.size() > 0 && sq_due[0] <= cyc_n) begin
            {s_err_i, s_dat_i} = sq_rsp.pop_front();
            s_ack_i = ~s_err_i;
            void'(sq_due.pop_front());
        end else begin
            s_ack_i = 0; s_err_i = 0; s_dat_i = $urandom;
        end
        m0_stb_i = en0 && (q0.size() > 0) && (!rnd || $urandom_range(1) == 1);
        if (m0_stb_i && !stb0_q) req0_cyc = cyc_n;
        stb0_q   = m0_stb_i;
        m0_adr_i = (q0.size() > 0) ? q0[0] : '0;
        m0_we_i  = m0_adr_i[2]; m0_dat_i = ~m0_adr_i; m0_sel_i = 4'hf;
        m0_cyc_i = keep0 || m0_stb_i || pend0 > 0;
        m1_stb_i = en1 && !kill1 && (q1.size() > 0) && (!rnd || $urandom_range(1) == 1);
        m1_adr_i = (q1.size() > 0) ? q1[0] : '0;
        m1_we_i  = m1_adr_i[3]; m1_dat_i = m1_adr_i ^ 32'h0f0f_0f0f; m1_sel_i = m1_adr_i[7:4];
        m1_cyc_i = !kill1 && (m1_stb_i || pend1 > 0);
    end

    // Observe phase: on the falling edge record accepts, routing and responses into the model
    always @(negedge clk) begin : mon
        logic [32:0] rsp;
        bit a0, a1, sa;
        if (!rst) begin
            a0 = m0_cyc_i && m0_stb_i && !m0_stall_o;
            a1 = m1_cyc_i && m1_stb_i && !m1_stall_o;
            sa = s_stb_o && !s_stall_i;
            if ((a0 || a1) != sa || (a0 && a1)) derr++;
            if ((a0 && s_adr_o !== m0_adr_i) || (a1 && s_adr_o !== m1_adr_i)) derr++;
            if (sa) begin
                rsp = {rnd && ($urandom_range(7) == 0), mem(s_adr_o)};
                sq_due.push_back(cyc_n + (rnd ? int'($urandom_range(5, 1)) : dly));
                sq_rsp.push_back(rsp);
            end
            if (a0) begin void'(q0.pop_front()); e0.push_back(rsp); acc0++; pend0++; acc_log.push_back(0); acc_cl.push_back(cyc_n); end
            if (a1) begin void'(q1.pop_front()); e1.push_back(rsp); acc1++; pend1++; acc_log.push_back(1); acc_cl.push_back(cyc_n); end
            if (m0_ack_o || m0_err_o) begin
                if (e0.size() == 0) stray++;
                else begin
                    rsp = e0.pop_front();
                    if ({m0_err_o, m0_ack_o ? m0_dat_o : rsp[31:0]} !== rsp || (m0_ack_o && m0_err_o)) derr++;
                    pend0--;
                end
                rsp0++; rsp0_cyc = cyc_n; rsp0_dat = m0_dat_o;
            end
            if (m1_ack_o || m1_err_o) begin
                if (e1.size() == 0) stray++;
                else begin
                    rsp = e1.pop_front();
                    if ({m1_err_o, m1_ack_o ? m1_dat_o : rsp[31:0]} !== rsp || (m1_ack_o && m1_err_o)) derr++;
                    pend1--;
                end
                rsp1++; last_rsp1_cyc = cyc_n;
            end
            if ((m0_ack_o || m0_err_o) && (m1_ack_o || m1_err_o)) both++;
            if (pend0 > maxp) maxp = pend0;
            if (pend1 > maxp) maxp = pend1;
        end
    end

    task automatic clr();
        @(negedge clk); #1;
        acc_log.delete(); acc_cl.delete(); maxp = 0;
    endtask

    task automatic test_reset();
        int n;
        rst = 1;
        repeat (3) @(negedge clk);
        #1;
        tests++;
        if ({s_cyc_o, s_stb_o, s_we_o, m0_stall_o, m1_stall_o, m0_ack_o, m1_ack_o, m0_err_o, m1_err_o, s_sel_o} !== 13'b00011_0000_0000 ||
            s_adr_o !== '0 || s_dat_o !== '0) begin
            fails++; $display("FAIL reset_init: ctl=%b adr=%h dat=%h", {s_cyc_o, s_stb_o, s_we_o, m0_stall_o, m1_stall_o}, s_adr_o, s_dat_o);
        end
        @(posedge clk); #2 rst = 0;
        dly = 4; keep0 = 0;
        clr();
        q0.push_back(32'h0000_0100); q0.push_back(32'h0000_0104);
        n = 0;
        while (pend0 < 2 && n < 50) begin @(negedge clk); #1; n++; end
        tests++;
        if (n >= 50 || s_cyc_o !== 1'b1) begin fails++; $display("FAIL reset_busy: pend=%0d s_cyc=%b want 2/1", pend0, s_cyc_o); end
        rst = 1; #1;
        tests++;
        if ({s_cyc_o, s_stb_o, s_we_o, m0_stall_o, m1_stall_o, m0_ack_o, m1_ack_o, m0_err_o, m1_err_o, s_sel_o} !== 13'b00011_0000_0000 ||
            s_adr_o !== '0 || s_dat_o !== '0) begin
            fails++; $display("FAIL reset_mid: ctl=%b adr=%h want 00011/0", {s_cyc_o, s_stb_o, s_we_o, m0_stall_o, m1_stall_o}, s_adr_o);
        end
        q0.delete(); e0.delete(); pend0 = 0;
        @(posedge clk); #2 rst = 0;
        n = rsp0;
        repeat (6) @(negedge clk);
        #1;
        tests++;
        if (rsp0 !== n) begin fails++; $display("FAIL reset_stray_ack: got %0d acks want 0", rsp0 - n); end
    endtask

    task automatic test_solo_fetch();
        int n, b0, b1;
        keep0 = 1; dly = 2;
        clr();
        b0 = rsp0; b1 = rsp1;
        q0.push_back(32'h8000_0004);
        n = 0;
        while (rsp0 == b0 && n < 40) begin @(negedge clk); #1; n++; end
        tests++;
        if (n >= 40 || acc_cl.size() != 1) begin fails++; $display("FAIL solo_timeout: acks=%0d accepts=%0d want 1/1", rsp0 - b0, acc_cl.size()); end
        else begin
            tests++;
            if (acc_cl[0] != req0_cyc + 1) begin fails++; $display("FAIL solo_grant_latency: got %0d want 1", acc_cl[0] - req0_cyc); end
            tests++;
            if (rsp0_cyc != acc_cl[0] + 2) begin fails++; $display("FAIL solo_ack_time: got %0d want 2", rsp0_cyc - acc_cl[0]); end
        end
        tests++;
        if (rsp0_dat !== 32'h0000_0013 || rsp1 != b1 || derr != 0) begin
            fails++; $display("FAIL solo_data: dat=%h m1acks=%0d derr=%0d want 00000013/0/0", rsp0_dat, rsp1 - b1, derr);
        end
    endtask

    task automatic test_tie();
        int n;
        dly = 3;
        clr();
        q0.push_back(32'h0000_2000); q1.push_back(32'h0000_3000);
        n = 0;
        while ((acc_log.size() < 2 || pend0 + pend1 > 0) && n < 60) begin @(negedge clk); #1; n++; end
        tests++;
        if (n >= 60 || acc_log.size() != 2) begin fails++; $display("FAIL tie_timeout: accepts=%0d want 2", acc_log.size()); end
        else begin
            tests++;
            if (acc_log[0] != 1 || acc_log[1] != 0) begin fails++; $display("FAIL tie_order: got %0d,%0d want 1,0", acc_log[0], acc_log[1]); end
            tests++;
            if (acc_cl[1] != last_rsp1_cyc + 1) begin fails++; $display("FAIL tie_no_bubble: gap %0d want 1", acc_cl[1] - last_rsp1_cyc); end
        end
    endtask

    task automatic test_burst();
        int n, bad;
        dly = 2;
        clr();
        for (int i = 0; i < 12; i++) q0.push_back(32'h0000_1000 + 32'(i * 4));
        n = 0;
        while (acc_log.size() == 0 && n < 20) begin @(negedge clk); #1; n++; end
        q1.push_back(32'h0000_4000);
        n = 0;
        while ((acc_log.size() < 13 || pend0 + pend1 > 0) && n < 200) begin @(negedge clk); #1; n++; end
        tests++;
        if (n >= 200 || acc_log.size() != 13) begin fails++; $display("FAIL burst_timeout: accepts=%0d want 13", acc_log.size()); end
        else begin
            bad = 0;
            for (int i = 0; i < 13; i++) if (acc_log[i] != ((i == 8) ? 1 : 0)) bad++;
            tests++;
            if (bad != 0) begin fails++; $display("FAIL burst_order: %0d misplaced accepts, want 8xM0,M1,4xM0", bad); end
            tests++;
            if (acc_cl[8] - acc_cl[7] != dly + 1) begin fails++; $display("FAIL burst_drain: gap %0d want %0d", acc_cl[8] - acc_cl[7], dly + 1); end
            tests++;
            if (acc_cl[9] - acc_cl[8] != dly + 1) begin fails++; $display("FAIL burst_resume: gap %0d want %0d", acc_cl[9] - acc_cl[8], dly + 1); end
        end
    endtask

    task automatic test_outstanding();
        int n;
        dly = 6;
        clr();
        for (int i = 0; i < 6; i++) q0.push_back(32'h0000_5000 + 32'(i * 4));
        n = 0;
        while ((acc_log.size() < 6 || pend0 > 0) && n < 100) begin @(negedge clk); #1; n++; end
        tests++;
        if (n >= 100 || acc_cl.size() != 6) begin fails++; $display("FAIL outst_timeout: accepts=%0d want 6", acc_cl.size()); end
        else begin
            tests++;
            if (maxp != 4) begin fails++; $display("FAIL outst_max: got %0d want 4", maxp); end
            tests++;
            if (acc_cl[3] - acc_cl[0] != 3 || acc_cl[4] - acc_cl[0] != 7) begin
                fails++; $display("FAIL outst_fifth_stalled: 4th at +%0d 5th at +%0d want +3/+7", acc_cl[3] - acc_cl[0], acc_cl[4] - acc_cl[0]);
            end
            tests++;
            if (acc_cl[5] - acc_cl[4] != 1) begin fails++; $display("FAIL outst_acc_ack_same: gap %0d want 1", acc_cl[5] - acc_cl[4]); end
        end
    endtask

    task automatic test_abort();
        int n, b1;
        dly = 6;
        clr();
        for (int i = 0; i < 3; i++) q1.push_back(32'h0000_6000 + 32'(i * 4));
        n = 0;
        while (pend1 < 3 && n < 40) begin @(negedge clk); #1; n++; end
        tests++;
        if (n >= 40) begin fails++; $display("FAIL abort_setup: pend=%0d want 3", pend1); end
        kill1 = 1;
        @(posedge clk); #2;
        tests++;
        if (s_cyc_o !== 1'b0 || s_stb_o !== 1'b0) begin fails++; $display("FAIL abort_cyc_drop: cyc=%b stb=%b want 0/0", s_cyc_o, s_stb_o); end
        e1.delete(); pend1 = 0; b1 = rsp1;
        @(posedge clk); #2;
        tests++;
        if (m1_stall_o !== 1'b1 || m0_stall_o !== 1'b1) begin fails++; $display("FAIL abort_idle: stall1=%b stall0=%b want 1/1", m1_stall_o, m0_stall_o); end
        repeat (8) @(negedge clk);
        #1;
        tests++;
        if (rsp1 != b1 || stray != 0) begin fails++; $display("FAIL abort_stray: acks=%0d stray=%0d want 0/0", rsp1 - b1, stray); end
        kill1 = 0; dly = 2;
        q1.push_back(32'h0000_7000);
        n = 0;
        while (rsp1 == b1 && n < 40) begin @(negedge clk); #1; n++; end
        repeat (2) @(negedge clk);
        #1;
        tests++;
        if (n >= 40 || derr != 0 || m1_stall_o !== 1'b1) begin
            fails++; $display("FAIL abort_restart: waited=%0d derr=%0d stall1=%b want <40/0/1", n, derr, m1_stall_o);
        end
    endtask

    task automatic test_random();
        int n, a0, a1, r0, r1;
        rnd = 1;
        clr();
        a0 = acc0; a1 = acc1; r0 = rsp0; r1 = rsp1;
        for (int c = 0; c < 400; c++) begin
            if (q0.size() < 6 && $urandom_range(2) == 0) q0.push_back($urandom & 32'hffff_fffc);
            if (q1.size() < 6 && $urandom_range(2) == 0) q1.push_back($urandom & 32'hffff_fffc);
            @(negedge clk); #1;
        end
        n = 0;
        while ((q0.size() + q1.size() + pend0 + pend1 > 0) && n < 3000) begin @(negedge clk); #1; n++; end
        rnd = 0;
        tests++;
        if (n >= 3000) begin fails++; $display("FAIL rand_timeout: q=%0d/%0d pend=%0d/%0d", q0.size(), q1.size(), pend0, pend1); end
        tests++;
        if (derr != 0) begin fails++; $display("FAIL rand_data_route: got %0d errors want 0", derr); end
        tests++;
        if (stray != 0 || both != 0) begin fails++; $display("FAIL rand_stray: stray=%0d both=%0d want 0/0", stray, both); end
        tests++;
        if (maxp > 4) begin fails++; $display("FAIL rand_outstanding: got %0d want <=4", maxp); end
        tests++;
        if (acc0 - a0 != rsp0 - r0 || acc1 - a1 != rsp1 - r1 || acc0 == a0 || acc1 == a1) begin
            fails++; $display("FAIL rand_counts: acc %0d/%0d rsp %0d/%0d want equal and nonzero", acc0 - a0, acc1 - a1, rsp0 - r0, rsp1 - r1);
        end
    endtask

    initial begin
        test_reset();
        test_solo_fetch();
        test_tie();
        test_burst();
        test_outstanding();
        test_abort();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
